// File: rtl/id_pkg.sv
// Shared opcode/funct/ALU encodings and the packed DX control bundle
// used by the instruction-decode stage.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_J     = 6'd2;

    localparam logic [5:0] F_ADD = 6'd32;
    localparam logic [5:0] F_SUB = 6'd34;
    localparam logic [5:0] F_AND = 6'd36;
    localparam logic [5:0] F_OR  = 6'd37;
    localparam logic [5:0] F_SLT = 6'd42;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_BEQ = 3'd5;
    localparam logic [2:0] ALU_SUB = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    typedef struct packed {
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       jump;
        logic [2:0] aluctr;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_regfile.sv
// NREG x XLEN register file: one write port, two write-first read ports.
// Out-of-range indices read 0 and drop writes; R0 optionally hardwired to 0.
module id_regfile #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int R0_ZERO = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr_a,
    input  logic [4:0]      raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    // Scanning the implemented entries keeps out-of-range indices at 0 for free.
    always_comb begin
        regs_d  = regs_q;
        rdata_a = '0;
        rdata_b = '0;
        for (int i = 0; i < NREG; i++) begin
            if (!(R0_ZERO != 0 && i == 0)) begin
                if (we && waddr == 5'(i))
                    regs_d[i] = wdata;
                if (raddr_a == 5'(i))
                    rdata_a = (we && waddr == raddr_a) ? wdata : regs_q[i];
                if (raddr_b == 5'(i))
                    rdata_b = (we && waddr == raddr_b) ? wdata : regs_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/id_stage_hz.sv
// Decode stage between IF and EX: register read, decode, load-use hazard
// detection, stall/flush handling and a registered DX bundle.
module id_stage_hz
    import id_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int R0_ZERO = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_ir,
    input  logic            ex_stall,
    input  logic            flush,
    input  logic            wb_regwrite,
    input  logic            wb_memtoreg,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_mdr,
    input  logic [XLEN-1:0] wb_aluout,
    output logic            id_ready,
    output logic            dx_valid,
    output logic            memtoreg,
    output logic            regwrite,
    output logic            memread,
    output logic            memwrite,
    output logic            branch,
    output logic            jump,
    output logic [2:0]      aluctr,
    output logic [XLEN-1:0] jt,
    output logic [XLEN-1:0] dx_pc,
    output logic [XLEN-1:0] npc,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [XLEN-1:0] md,
    output logic [15:0]     imm,
    output logic [4:0]      rd,
    output logic            illegal
);

    logic [5:0]      op, funct;
    logic [4:0]      rs, rt;
    logic [XLEN-1:0] rs_val, rt_val, sext_imm, jt_dec;
    logic [XLEN-1:0] dec_b;
    logic [4:0]      dec_rd;
    ctrl_t           dec_ctrl;
    logic            dec_legal, uses_rt, load_use;

    logic            dx_valid_q, dx_valid_d, illegal_q, illegal_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic [XLEN-1:0] jt_q, jt_d, pc_q, pc_d, a_q, a_d, b_q, b_d, md_q, md_d;
    logic [15:0]     imm_q, imm_d;
    logic [4:0]      rd_q, rd_d;

    assign op       = if_ir[31:26];
    assign funct    = if_ir[5:0];
    assign rs       = if_ir[25:21];
    assign rt       = if_ir[20:16];
    assign sext_imm = {{(XLEN-16){if_ir[15]}}, if_ir[15:0]};
    assign jt_dec   = {if_pc[XLEN-1:28], if_ir[25:0], 2'b00};

    id_regfile #(.XLEN(XLEN), .NREG(NREG), .R0_ZERO(R0_ZERO)) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_regwrite),
        .waddr   (wb_rd),
        .wdata   (wb_memtoreg ? wb_mdr : wb_aluout),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rs_val),
        .rdata_b (rt_val)
    );

    always_comb begin
        dec_ctrl  = CTRL_NOP;
        dec_b     = rt_val;
        dec_rd    = '0;
        dec_legal = 1'b1;
        uses_rt   = 1'b0;
        case (op)
            OP_RTYPE: begin
                uses_rt           = 1'b1;
                dec_rd            = if_ir[15:11];
                dec_ctrl.regwrite = 1'b1;
                case (funct)
                    F_ADD:   dec_ctrl.aluctr = ALU_ADD;
                    F_SUB:   dec_ctrl.aluctr = ALU_SUB;
                    F_AND:   dec_ctrl.aluctr = ALU_AND;
                    F_OR:    dec_ctrl.aluctr = ALU_OR;
                    F_SLT:   dec_ctrl.aluctr = ALU_SLT;
                    default: dec_legal       = 1'b0;
                endcase
            end
            OP_LW: begin
                dec_b             = sext_imm;
                dec_rd            = rt;
                dec_ctrl.memtoreg = 1'b1;
                dec_ctrl.regwrite = 1'b1;
                dec_ctrl.memread  = 1'b1;
                dec_ctrl.aluctr   = ALU_ADD;
            end
            OP_SW: begin
                uses_rt           = 1'b1;
                dec_b             = sext_imm;
                dec_ctrl.memwrite = 1'b1;
                dec_ctrl.aluctr   = ALU_ADD;
            end
            OP_ADDI: begin
                dec_b             = sext_imm;
                dec_rd            = rt;
                dec_ctrl.regwrite = 1'b1;
                dec_ctrl.aluctr   = ALU_ADD;
            end
            OP_BEQ, OP_BNE: begin
                uses_rt         = 1'b1;
                dec_ctrl.branch = 1'b1;
                dec_ctrl.aluctr = (op == OP_BEQ) ? ALU_BEQ : ALU_SUB;
            end
            OP_J: begin
                dec_b         = '0;
                dec_ctrl.jump = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // A load in DX whose destination feeds this instruction must slip one cycle.
    assign load_use = dx_valid_q && ctrl_q.memread && (rd_q != 5'd0) &&
                      ((rd_q == rs) || (uses_rt && (rd_q == rt))) && if_valid;

    assign id_ready = !(load_use && !flush) && !ex_stall;

    always_comb begin
        dx_valid_d = dx_valid_q;
        illegal_d  = 1'b0;
        ctrl_d     = ctrl_q;
        jt_d       = jt_q;
        pc_d       = pc_q;
        a_d        = a_q;
        b_d        = b_q;
        md_d       = md_q;
        imm_d      = imm_q;
        rd_d       = rd_q;
        if (flush || !ex_stall) begin
            jt_d       = jt_dec;
            pc_d       = if_pc;
            a_d        = rs_val;
            b_d        = dec_b;
            md_d       = rt_val;
            imm_d      = if_ir[15:0];
            rd_d       = dec_rd;
            ctrl_d     = CTRL_NOP;
            dx_valid_d = 1'b0;
            if (!flush && !load_use && if_valid) begin
                if (dec_legal) begin
                    ctrl_d     = dec_ctrl;
                    dx_valid_d = 1'b1;
                end else begin
                    illegal_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dx_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            ctrl_q     <= CTRL_NOP;
            jt_q       <= '0;
            pc_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            md_q       <= '0;
            imm_q      <= '0;
            rd_q       <= '0;
        end else begin
            dx_valid_q <= dx_valid_d;
            illegal_q  <= illegal_d;
            ctrl_q     <= ctrl_d;
            jt_q       <= jt_d;
            pc_q       <= pc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            md_q       <= md_d;
            imm_q      <= imm_d;
            rd_q       <= rd_d;
        end
    end

    assign dx_valid = dx_valid_q;
    assign illegal  = illegal_q;
    assign memtoreg = ctrl_q.memtoreg;
    assign regwrite = ctrl_q.regwrite;
    assign memread  = ctrl_q.memread;
    assign memwrite = ctrl_q.memwrite;
    assign branch   = ctrl_q.branch;
    assign jump     = ctrl_q.jump;
    assign aluctr   = ctrl_q.aluctr;
    assign jt       = jt_q;
    assign dx_pc    = pc_q;
    assign npc      = pc_q;
    assign a        = a_q;
    assign b        = b_q;
    assign md       = md_q;
    assign imm      = imm_q;
    assign rd       = rd_q;

endmodule
